// File: rtl/sr_iter_shifter.sv
// Multi-cycle SRL/SRA: one power-of-two stage per cycle (largest first), fixed latency.
// Ports: clock/reset (async, active-high); ctrl_start, data_in, shamt, arith in;
//        data_out (held result), data_rdy (1-cycle pulse), busy (shift in flight) out.
module sr_iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_rdy,
  output logic               busy
);

  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   stage_q, stage_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               arith_q, arith_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               data_rdy_q, data_rdy_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   bit_idx;
  logic [SHAMT_W-1:0] amt;
  logic               fill;
  logic [WIDTH-1:0]   shifted;

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    work_d     = work_q;
    shamt_d    = shamt_q;
    arith_d    = arith_q;
    data_out_d = data_out_q;

    // Stage k consumes shamt bit SHAMT_W-1-k, i.e. the largest stage goes first.
    bit_idx = LAST_STAGE - stage_q;
    // Every SRA stage keeps the MSB, so the working MSB is still the operand's sign.
    fill    = arith_q & work_q[WIDTH-1];
    amt     = shamt_q[bit_idx] ? (SHAMT_W'(1) << bit_idx) : '0;
    shifted = WIDTH'({{WIDTH{fill}}, work_q} >> amt);

    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_start) begin
          work_d  = data_in;
          shamt_d = shamt;
          arith_d = arith;
          stage_d = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // ctrl_start is deliberately ignored here: no queueing, no abort.
        work_d  = shifted;
        stage_d = stage_q + 1'b1;
        if (stage_q == LAST_STAGE) begin
          data_out_d = shifted;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == SHIFT);
    data_rdy_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      work_q     <= '0;
      shamt_q    <= '0;
      arith_q    <= 1'b0;
      data_out_q <= '0;
      data_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      work_q     <= work_d;
      shamt_q    <= shamt_d;
      arith_q    <= arith_d;
      data_out_q <= data_out_d;
      data_rdy_q <= data_rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out = data_out_q;
  assign data_rdy = data_rdy_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sr_iter_shifter.sv
module tb_sr_iter_shifter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic [31:0] data_out;
  logic        data_rdy;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sr_iter_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_start (ctrl_start),
    .data_in    (data_in),
    .shamt      (shamt),
    .arith      (arith),
    .data_out   (data_out),
    .data_rdy   (data_rdy),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Behavioural model: a job is a countdown of 5 edges; result computed up front.
  int          m_rem = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_out = '0;
  logic        m_rdy = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_rem = 0;
      m_pend = '0;
      m_out = '0;
      m_rdy = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_out = m_pend;
          m_rdy = 1'b1;
        end
      end else if (ctrl_start) begin
        if (arith) m_pend = $signed(data_in) >>> shamt;
        else       m_pend = data_in >> shamt;
        m_rem = 5;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("data_out", data_out, m_out);
    check("data_rdy", {31'd0, data_rdy}, {31'd0, m_rdy});
    check("busy",     {31'd0, busy},     {31'd0, (m_rem > 0)});
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_start(input logic [31:0] d, input logic [4:0] s, input logic a);
    tick();
    ctrl_start = 1'b1; data_in = d; shamt = s; arith = a;
    tick();
    ctrl_start = 1'b0; data_in = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
  endtask

  // Counts negedges until data_rdy; the bound keeps a dead DUT from hanging the run.
  task automatic wait_rdy(output int cnt);
    cnt = 0;
    while (!data_rdy && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    #1;
  endtask

  int lat;

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    check("reset_out",  data_out, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // 1: SRL by 8, latency 5, one-cycle pulse
    do_start(32'h80000000, 5'd8, 1'b0);
    wait_rdy(lat);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_result", data_out, 32'h00800000);
    check("t1_model", m_out, 32'h00800000);
    tick();
    check("t1_pulse_len", {31'd0, data_rdy}, 32'd0);

    // 2: SRA sign fill both polarities
    do_start(32'h80000000, 5'd8, 1'b1);
    wait_rdy(lat);
    check("t2_sra_neg", data_out, 32'hFF800000);
    do_start(32'h7FFFFFFF, 5'd8, 1'b1);
    wait_rdy(lat);
    check("t2_sra_pos", data_out, 32'h007FFFFF);

    // 3: shamt extremes
    do_start(32'hF0000000, 5'd31, 1'b1);
    wait_rdy(lat);
    check("t3_sra31", data_out, 32'hFFFFFFFF);
    do_start(32'hF0000000, 5'd31, 1'b0);
    wait_rdy(lat);
    check("t3_srl31", data_out, 32'h00000001);
    do_start(32'h12345678, 5'd0, 1'b0);
    wait_rdy(lat);
    check("t3_zero_lat", 32'(lat), 32'd5);
    check("t3_zero", data_out, 32'h12345678);

    // 4: start pulse during SHIFT is ignored
    do_start(32'hAAAA0000, 5'd4, 1'b0);
    ctrl_start = 1'b1; data_in = 32'h55555555; shamt = 5'd1; arith = 1'b1;
    tick();
    ctrl_start = 1'b0;
    wait_rdy(lat);
    check("t4_ignored", data_out, 32'h0AAAA000);
    check("t4_latency", 32'(lat), 32'd4);

    // 5: start held through the data_rdy cycle gives back-to-back jobs
    tick();
    ctrl_start = 1'b1; data_in = 32'h80000000; shamt = 5'd4; arith = 1'b1;
    tick();
    data_in = 32'h0000F000; shamt = 5'd12; arith = 1'b0;
    wait_rdy(lat);
    check("t5_first", data_out, 32'hF8000000);
    tick();
    ctrl_start = 1'b0;
    check("t5_busy_again", {31'd0, busy}, 32'd1);
    check("t5_hold", data_out, 32'hF8000000);
    wait_rdy(lat);
    check("t5_second_lat", 32'(lat), 32'd5);
    check("t5_second", data_out, 32'h0000000F);

    // 6: reset mid-shift cancels the job
    do_start(32'hDEADBEEF, 5'd3, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check("t6_out", data_out, 32'h0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("t6_no_rdy", {31'd0, data_rdy}, 32'd0);
    do_start(32'hDEADBEEF, 5'd4, 1'b1);
    wait_rdy(lat);
    check("t6_after", data_out, 32'hFDEADBEE);

    // Random traffic: starts at any time, occasional resets
    for (int i = 0; i < 600; i++) begin
      tick();
      ctrl_start = ($urandom_range(0, 3) == 0);
      data_in    = $urandom;
      shamt      = 5'($urandom);
      arith      = 1'($urandom);
      reset      = ($urandom_range(0, 150) == 0);
    end
    tick();
    reset = 1'b0;
    ctrl_start = 1'b0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
